// File: rtl/seq_arith_unit_if.sv
// seq_arith_unit_if: handshake/data bundle between an operand source/result consumer and
// seq_arith_unit.
//   in_valid/in_ready/op/a/b          : operand channel (source -> unit)
//   out_valid/out_ready/result/carry_o : result channel (unit -> consumer)
//   busy                               : unit is in CALC or DONE
// Modports: master = source/consumer side, slave = arithmetic unit side.
interface seq_arith_unit_if #(
    parameter int unsigned WIDTH = 6
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 carry_o;
    logic                 busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry_o, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry_o, busy
    );
endinterface

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned ADD / SUB / MUL unit with valid/ready handshakes.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : seq_arith_unit_if.slave (operands in, result/carry_o out, busy)
// op encoding: 00 ADD, 01 SUB, 10 MUL (shift-add, one multiplier bit per cycle), 11 reserved.
// Optional feature macro SEQ_ARITH_EARLY_TERM_EN: MUL leaves CALC as soon as the remaining
// multiplier bits are all zero (result unchanged, latency shorter for small b).
module seq_arith_unit #(
    parameter int unsigned WIDTH = 6
) (
    input logic              clk,
    input logic              rst_n,
    seq_arith_unit_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 carry_q, carry_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;

    // Extra top bit captures carry-out; for SUB it is the "no borrow" flag.
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        carry_d  = carry_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    count_d  = '0;
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    state_d  = StDone;
                    case (bus.op)
                        2'b00: begin
                            acc_d   = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
                            carry_d = sum[WIDTH];
                        end
                        2'b01: begin
                            acc_d   = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
                            carry_d = diff[WIDTH];
                        end
                        2'b10: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                            state_d = StCalc;
                        end
                        default: begin
                            acc_d   = '0;
                            carry_d = 1'b0;
                        end
                    endcase
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
`ifdef SEQ_ARITH_EARLY_TERM_EN
                // No set bits left means no further partial products to add.
                if (mplier_d == '0) begin
                    state_d = StDone;
                end
`else
                if (count_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = acc_q;
    assign bus.carry_o   = carry_q;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit at WIDTH=6; expected values are hand-computed.
module tb_seq_arith_unit;
    localparam int unsigned W = 6;
`ifdef SEQ_ARITH_EARLY_TERM_EN
    localparam bit EarlyTerm = 1'b1;
`else
    localparam bit EarlyTerm = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_arith_unit_if #(.WIDTH(W)) bus ();

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("in_ready wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Issue one op, measure cycles from accept to out_valid, optionally stall the consumer.
    task automatic do_op(input string tag, input logic [1:0] op, input int a, input int b,
                         input int exp_res, input int exp_carry, input int exp_lat,
                         input int stall);
        int lat;
        wait_ready();
        bus.op       = op;
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        check_eq({tag, " busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, " in_ready low"}, 32'(bus.in_ready), 32'd0);
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " result"}, 32'(bus.result), 32'(exp_res));
        check_eq({tag, " carry"}, 32'(bus.carry_o), 32'(exp_carry));
        for (int i = 0; i < stall; i++) begin
            // New request while holding a result must be ignored.
            bus.in_valid = 1'b1;
            bus.op       = 2'b00;
            bus.a        = W'(1);
            bus.b        = W'(1);
            tick();
            check_eq({tag, " stall result"}, 32'(bus.result), 32'(exp_res));
            check_eq({tag, " stall carry"}, 32'(bus.carry_o), 32'(exp_carry));
            check_eq({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq({tag, " idle in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, " idle out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        tick();
        tick();
        check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset result", 32'(bus.result), 32'd0);
        check_eq("reset carry", 32'(bus.carry_o), 32'd0);
        check_eq("reset busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("add 63+1",  2'b00, 63, 1,  0,  1, 1, 0);
        do_op("add 20+22", 2'b00, 20, 22, 42, 0, 1, 0);
        do_op("sub 7-5",   2'b01, 7,  5,  2,  1, 1, 0);
        do_op("sub 5-7",   2'b01, 5,  7,  62, 0, 1, 0);
        do_op("sub 9-9",   2'b01, 9,  9,  0,  1, 1, 0);
        do_op("rsvd",      2'b11, 10, 5,  0,  0, 1, 0);
        do_op("mul 63*63", 2'b10, 63, 63, 3969, 0, 7, 0);
        do_op("mul 0*45",  2'b10, 0,  45, 0,  0, 7, 0);
        do_op("mul 5*3",   2'b10, 5,  3,  15, 0, EarlyTerm ? 3 : 7, 0);
        do_op("mul 5*0",   2'b10, 5,  0,  0,  0, EarlyTerm ? 2 : 7, 0);
        do_op("mul 5*32",  2'b10, 5,  32, 160, 0, 7, 0);
        do_op("mul 12*11", 2'b10, 12, 11, 132, 0, EarlyTerm ? 5 : 7, 5);

        // Reset in the 3rd CALC cycle of a MUL discards it.
        wait_ready();
        bus.op       = 2'b10;
        bus.a        = W'(63);
        bus.b        = W'(63);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_eq("pre-reset busy", 32'(bus.busy), 32'd1);
        check_eq("pre-reset out_valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("mid reset in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("mid reset result", 32'(bus.result), 32'd0);
        check_eq("mid reset busy", 32'(bus.busy), 32'd0);
        do_op("add 3+4", 2'b00, 3, 4, 7, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
